// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Single-port behavioural memory responder. It accepts one request at a time
//   on a valid/ready address channel. Writes carry masked data on a separate
//   data channel, which may arrive in the same cycle as the request or later.
//   A read returns BURST consecutive beats starting LATENCY cycles after the
//   request is accepted. The beat index wraps at the top of storage.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   mem_req_valid       request (address/command) valid
//   mem_req_ready       responder idle and able to take a request
//   mem_req_addr        beat address; only the low DEPTH_BITS index storage
//   mem_req_rw          1 = write, 0 = read
//   mem_req_data_valid  write data valid
//   mem_req_data_ready  responder able to take write data
//   mem_req_data_bits   write data
//   mem_req_data_mask   byte enables; bit i covers bits 8i+7:8i
//   mem_resp_valid      read beat valid (registered)
//   mem_resp_data       read beat data, all-zero when not valid (registered)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int MEM_DATA_BITS = 128,
    parameter int ADDR_BITS     = 28,
    parameter int DEPTH_BITS    = 10,
    parameter int LATENCY       = 4,
    parameter int BURST         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_req_valid,
    output logic                       mem_req_ready,
    input  logic [ADDR_BITS-1:0]       mem_req_addr,
    input  logic                       mem_req_rw,
    input  logic                       mem_req_data_valid,
    output logic                       mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                       mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int DEPTH  = 1 << DEPTH_BITS;
    localparam int NBYTES = MEM_DATA_BITS / 8;
    localparam int CNT_W  = 4;
    localparam int BEAT_W = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } state_t;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
        input logic [MEM_DATA_BITS-1:0] old_word,
        input logic [MEM_DATA_BITS-1:0] new_word,
        input logic [NBYTES-1:0]        byte_en
    );
        logic [MEM_DATA_BITS-1:0] result;
        result = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    logic [MEM_DATA_BITS-1:0] mem_r [DEPTH];

    state_t                   state_r;
    state_t                   state_s;
    logic [DEPTH_BITS-1:0]    addr_r;
    logic [DEPTH_BITS-1:0]    addr_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_s;
    logic [BEAT_W-1:0]        beat_r;
    logic [BEAT_W-1:0]        beat_s;
    logic                     resp_valid_r;
    logic                     resp_valid_s;
    logic [MEM_DATA_BITS-1:0] resp_data_r;
    logic [MEM_DATA_BITS-1:0] resp_data_s;
    logic                     ready_s;
    logic                     data_ready_s;
    logic                     wr_en_s;
    logic                     wr_commit_s;
    logic [DEPTH_BITS-1:0]    wr_idx_s;
    logic [DEPTH_BITS-1:0]    rd_idx_s;

    // Upper address bits do not select storage.
    generate
        if (ADDR_BITS > DEPTH_BITS) begin : g_unused_addr
            logic unused_addr_s;
            assign unused_addr_s = ^mem_req_addr[ADDR_BITS-1:DEPTH_BITS];
        end
    endgenerate

    // Beat index is modulo storage depth, so the sum simply truncates.
    assign rd_idx_s = addr_r + DEPTH_BITS'(beat_r);

    // Handshake outputs are held low while reset is asserted.
    assign mem_req_ready      = ready_s && !reset;
    assign mem_req_data_ready = data_ready_s && !reset;
    // A write never lands on an edge where reset is high.
    assign wr_commit_s        = wr_en_s && !reset;

    assign mem_resp_valid = resp_valid_r;
    assign mem_resp_data  = resp_data_r;

    // Next-state, handshake and next-response logic.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        cnt_s        = cnt_r;
        beat_s       = beat_r;
        resp_valid_s = 1'b0;
        resp_data_s  = {MEM_DATA_BITS{1'b0}};
        ready_s      = 1'b0;
        data_ready_s = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = addr_r;

        case (state_r)
            IDLE: begin
                ready_s      = 1'b1;
                data_ready_s = mem_req_valid && mem_req_rw;
                if (mem_req_valid) begin
                    addr_s = mem_req_addr[DEPTH_BITS-1:0];
                    if (mem_req_rw) begin
                        if (mem_req_data_valid) begin
                            // Data arrived with the request: commit now, stay idle.
                            wr_en_s  = 1'b1;
                            wr_idx_s = mem_req_addr[DEPTH_BITS-1:0];
                            state_s  = IDLE;
                        end else begin
                            state_s = WR_DATA;
                        end
                    end else begin
                        // Countdown reaches zero on the edge before the first beat.
                        state_s = RD_WAIT;
                        cnt_s   = CNT_W'(LATENCY - 1);
                        beat_s  = {BEAT_W{1'b0}};
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            WR_DATA: begin
                data_ready_s = 1'b1;
                if (mem_req_data_valid) begin
                    wr_en_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WR_DATA;
                end
            end

            RD_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    resp_valid_s = 1'b1;
                    resp_data_s  = mem_r[rd_idx_s];
                    beat_s       = beat_r + BEAT_W'(1);
                    state_s      = RD_BURST;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end

            RD_BURST: begin
                if (beat_r == BEAT_W'(BURST)) begin
                    // Last beat is on the wire now; drop valid and free up.
                    state_s = IDLE;
                end else begin
                    resp_valid_s = 1'b1;
                    resp_data_s  = mem_r[rd_idx_s];
                    beat_s       = beat_r + BEAT_W'(1);
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            addr_r       <= {DEPTH_BITS{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            beat_r       <= {BEAT_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_data_r  <= {MEM_DATA_BITS{1'b0}};
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            cnt_r        <= cnt_s;
            beat_r       <= beat_s;
            resp_valid_r <= resp_valid_s;
            resp_data_r  <= resp_data_s;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[wr_idx_s] <= merge_bytes(mem_r[wr_idx_s], mem_req_data_bits, mem_req_data_mask);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int DW    = 128;
    localparam int AW    = 28;
    localparam int DB    = 10;
    localparam int LAT   = 4;
    localparam int BUR   = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << DB;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [NB-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    mem_responder #(
        .MEM_DATA_BITS(DW),
        .ADDR_BITS    (AW),
        .DEPTH_BITS   (DB),
        .LATENCY      (LAT),
        .BURST        (BUR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_rw        (mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycle count, busy horizon, pending write, storage, expected beats.
    int            cyc      = 0;
    int            ready_at = 0;
    bit            pending  = 1'b0;
    logic [DB-1:0] pend_addr;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_beat [int];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte-masked update expressed as and/or with an expanded bit mask.
    task automatic model_write(input logic [DB-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
        logic [DW-1:0] bitmask;
        bitmask = {DW{1'b0}};
        for (int i = 0; i < NB; i++) begin
            if (m[i]) bitmask = bitmask | ({{(DW-8){1'b0}}, 8'hFF} << (8 * i));
        end
        mem_m[a] = (mem_m[a] & ~bitmask) | (d & bitmask);
    endtask

    // Advance one clock: update the model from the handshakes seen before the
    // edge, then check every output shortly after the edge.
    task automatic tick();
        bit            acc;
        bit            dhs;
        bit            rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] m;
        bit            exp_rdy;
        bit            exp_dr;
        acc = mem_req_valid && !pending && (cyc >= ready_at);
        rw  = mem_req_rw;
        a   = mem_req_addr;
        d   = mem_req_data_bits;
        m   = mem_req_data_mask;
        dhs = mem_req_data_valid && (pending || (acc && rw));
        @(posedge clk);
        cyc++;
        if (acc && !rw) begin
            for (int k = 0; k < BUR; k++) begin
                exp_beat[cyc + LAT + k] = mem_m[(int'(a[DB-1:0]) + k) % DEPTH];
            end
            ready_at = cyc + LAT + BUR;
        end else if (acc && rw && dhs) begin
            model_write(a[DB-1:0], d, m);
        end else if (acc && rw) begin
            pending   = 1'b1;
            pend_addr = a[DB-1:0];
        end else if (pending && dhs) begin
            model_write(pend_addr, d, m);
            pending = 1'b0;
        end
        #1;
        exp_rdy = !pending && (cyc >= ready_at);
        exp_dr  = pending || (exp_rdy && mem_req_valid && mem_req_rw);
        check_eq("req_ready", {{(DW-1){1'b0}}, mem_req_ready}, {{(DW-1){1'b0}}, exp_rdy});
        check_eq("data_ready", {{(DW-1){1'b0}}, mem_req_data_ready}, {{(DW-1){1'b0}}, exp_dr});
        if (exp_beat.exists(cyc)) begin
            check_eq("resp_valid", {{(DW-1){1'b0}}, mem_resp_valid}, {{(DW-1){1'b0}}, 1'b1});
            check_eq("resp_data", mem_resp_data, exp_beat[cyc]);
            exp_beat.delete(cyc);
        end else begin
            check_eq("resp_valid", {{(DW-1){1'b0}}, mem_resp_valid}, {DW{1'b0}});
            check_eq("resp_data_idle", mem_resp_data, {DW{1'b0}});
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m, input int dly);
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = a;
        mem_req_data_bits  = d;
        mem_req_data_mask  = m;
        mem_req_data_valid = (dly == 0);
        tick();
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        if (dly > 0) begin
            mem_req_data_valid = 1'b0;
            mem_req_data_bits  = rand_word();
            repeat (dly - 1) tick();
            mem_req_data_bits  = d;
            mem_req_data_mask  = m;
            mem_req_data_valid = 1'b1;
            tick();
        end
        mem_req_data_valid = 1'b0;
    endtask

    // Issue a read and run until the model says the responder is free again;
    // stray write-data pulses during the read must be ignored.
    task automatic rd(input logic [AW-1:0] a);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = a;
        tick();
        mem_req_valid = 1'b0;
        while (cyc < ready_at) begin
            mem_req_data_valid = 1'($urandom_range(0, 1));
            mem_req_data_bits  = rand_word();
            mem_req_data_mask  = NB'($urandom);
            tick();
        end
        mem_req_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_resp_valid", {{(DW-1){1'b0}}, mem_resp_valid}, {DW{1'b0}});
        check_eq("rst_resp_data", mem_resp_data, {DW{1'b0}});
        check_eq("rst_req_ready", {{(DW-1){1'b0}}, mem_req_ready}, {DW{1'b0}});
        check_eq("rst_data_ready", {{(DW-1){1'b0}}, mem_req_data_ready}, {DW{1'b0}});
        pending  = 1'b0;
        ready_at = 0;
        exp_beat.delete();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        reset              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = {AW{1'b0}};
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = {DW{1'b0}};
        mem_req_data_mask  = {NB{1'b0}};
        #1;
        reset         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        #1;
        // Handshakes stay low during reset even with a write request present.
        check_eq("init_resp_valid", {{(DW-1){1'b0}}, mem_resp_valid}, {DW{1'b0}});
        check_eq("init_resp_data", mem_resp_data, {DW{1'b0}});
        check_eq("init_req_ready", {{(DW-1){1'b0}}, mem_req_ready}, {DW{1'b0}});
        check_eq("init_data_ready", {{(DW-1){1'b0}}, mem_req_data_ready}, {DW{1'b0}});
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset = 1'b0;
        tick();

        // Fill storage so every later read has a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            wr(AW'(i), rand_word(), {NB{1'b1}}, 0);
        end

        // Same-cycle write then read-back.
        wr(28'h005, 128'h0008_0007_0006_0005_0004_0003_0002_0001, {NB{1'b1}}, 0);
        rd(28'h005);

        // Partial mask overwrite of the low 32 bits.
        wr(28'h010, {DW{1'b1}}, {NB{1'b1}}, 0);
        wr(28'h010, {DW{1'b0}}, 16'h000F, 0);
        rd(28'h010);

        // Write data arriving three cycles after the request.
        wr(28'h020, rand_word(), {NB{1'b1}}, 3);
        rd(28'h020);

        // Burst wrapping past the top of storage, with upper address bits set.
        wr(28'h3FE, 128'hAAAA_0000_0000_0000_0000_0000_0000_03FE, {NB{1'b1}}, 0);
        wr(28'h3FF, 128'hBBBB_0000_0000_0000_0000_0000_0000_03FF, {NB{1'b1}}, 0);
        wr(28'h000, 128'hCCCC_0000_0000_0000_0000_0000_0000_0000, {NB{1'b1}}, 0);
        wr(28'h001, 128'hDDDD_0000_0000_0000_0000_0000_0000_0001, {NB{1'b1}}, 0);
        rd(28'hABC_FFFE);

        // All-zero mask completes without altering storage.
        wr(28'h030, rand_word(), {NB{1'b0}}, 1);
        rd(28'h030);

        // Reset during the third beat aborts the burst.
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'h005;
        tick();
        mem_req_valid = 1'b0;
        repeat (LAT + 2) tick();
        do_reset();
        repeat (8) tick();
        rd(28'h005);

        // Reset while waiting for write data: the write must not land.
        w = rand_word();
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 28'h040;
        mem_req_data_valid = 1'b0;
        tick();
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        tick();
        do_reset();
        mem_req_data_bits  = w;
        mem_req_data_mask  = {NB{1'b1}};
        mem_req_data_valid = 1'b1;
        tick();
        mem_req_data_valid = 1'b0;
        rd(28'h040);

        // Stray write data in idle with no request is ignored.
        mem_req_addr       = 28'h005;
        mem_req_data_bits  = rand_word();
        mem_req_data_mask  = {NB{1'b1}};
        mem_req_data_valid = 1'b1;
        tick();
        mem_req_data_valid = 1'b0;
        rd(28'h005);

        // Randomised mix of reads, writes and idle noise.
        for (int n = 0; n < 250; n++) begin
            logic [AW-1:0] a;
            logic [NB-1:0] m;
            int            op;
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = {AW'($urandom) & {{(AW-DB){1'b1}}, {DB{1'b0}}}} | AW'(DEPTH - 1 - $urandom_range(0, 3));
            else a = AW'($urandom);
            m = ($urandom_range(0, 7) == 0) ? {NB{1'b0}} : NB'($urandom);
            if (op == 0 || op == 1) begin
                rd(a);
            end else if (op == 2) begin
                wr(a, rand_word(), m, $urandom_range(0, 4));
            end else begin
                mem_req_data_valid = 1'($urandom_range(0, 1));
                mem_req_data_bits  = rand_word();
                mem_req_data_mask  = m;
                repeat ($urandom_range(1, 3)) tick();
                mem_req_data_valid = 1'b0;
            end
        end
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
